// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and its datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [2:0] ImmSrc;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, retire, illegal, state
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, retire, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V sequencer: steps each instruction through fetch/decode/
// execute/memory/writeback and drives the shared ALU, memory port and regfile.
// Handshake: a memory access in FETCH/MEMREAD/MEMWRITE completes in the cycle
// mem_ready is 1; the controller holds every output stable until then.
module multicycle_ctrl (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] LUI      = 4'd11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state_q;
  logic [3:0] next_state;
  logic [2:0] alu_dec;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= next_state;
  end

  assign bus.state = state_q;

  // sub only for R-type funct7b5; addi with imm[10] set must stay an add
  always_comb begin
    case (bus.funct3)
      3'b000:  alu_dec = (bus.op[5] && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    case (bus.op)
      7'b0100011: bus.ImmSrc = 3'b001;
      7'b1100011: bus.ImmSrc = 3'b010;
      7'b1101111: bus.ImmSrc = 3'b011;
      7'b0110111: bus.ImmSrc = 3'b100;
      default:    bus.ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    next_state     = state_q;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = ALU_ADD;
    bus.retire     = 1'b0;
    bus.illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
        next_state    = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // ALU computes OldPC + imm here so BRANCH can reuse it from ALUOut
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.op)
          7'b0000011,
          7'b0100011: next_state = MEMADR;
          7'b0110011: next_state = EXECR;
          7'b0010011: next_state = EXECI;
          7'b1100011: next_state = BRANCH;
          7'b1101111: next_state = JAL;
          7'b0110111: next_state = LUI;
          default: begin
            next_state  = FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        next_state  = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        next_state = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        bus.retire    = 1'b1;
        next_state    = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        bus.retire   = bus.mem_ready;
        next_state   = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_dec;
        next_state     = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_dec;
        next_state     = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.retire   = 1'b1;
        next_state   = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = ALU_SUB;
        bus.PCWrite    = bus.zero ^ bus.funct3[0];
        bus.retire     = 1'b1;
        next_state     = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        next_state  = ALUWB;
      end
      LUI: begin
        bus.ALUSrcA = 2'b11;
        bus.ALUSrcB = 2'b01;
        next_state  = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the
// sequencer and compares outputs against hand-computed values.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_instr(input logic [31:0] instr);
    bus.op       = instr[6:0];
    bus.funct3   = instr[14:12];
    bus.funct7b5 = instr[30];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_branch(input string tag, input logic [31:0] instr,
                            input logic zero_v, input logic exp_pcw);
    load_instr(instr);
    bus.zero = 1'b0;
    settle();
    check({tag, "_s0"}, 32'(bus.state), 0);
    tick();
    settle();
    check({tag, "_s1"}, 32'(bus.state), 1);
    tick();
    bus.zero = zero_v;
    settle();
    check({tag, "_s9"}, 32'(bus.state), 9);
    check({tag, "_pcwrite"}, 32'(bus.PCWrite), 32'(exp_pcw));
    check({tag, "_immsrc"}, 32'(bus.ImmSrc), 2);
    check({tag, "_aluctl"}, 32'(bus.ALUControl), 1);
    check({tag, "_retire"}, 32'(bus.retire), 1);
    tick();
    bus.zero = 1'b0;
    settle();
    check({tag, "_back"}, 32'(bus.state), 0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    load_instr(32'h00000013);
    tick();
    settle();
    // reset state shows FETCH values
    check("rst_state", 32'(bus.state), 0);
    check("rst_retire", 32'(bus.retire), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    check("rst_memwrite", 32'(bus.MemWrite), 0);
    check("rst_regwrite", 32'(bus.RegWrite), 0);
    check("rst_irwrite", 32'(bus.IRWrite), 1);
    check("rst_pcwrite", 32'(bus.PCWrite), 1);
    bus.mem_ready = 1'b0;
    settle();
    check("rst_irwrite_lo", 32'(bus.IRWrite), 0);
    check("rst_pcwrite_lo", 32'(bus.PCWrite), 0);
    tick();
    reset = 1'b0;
    tick();

    // add x3,x1,x2 with one FETCH wait cycle first
    load_instr(32'h002081B3);
    bus.mem_ready = 1'b0;
    settle();
    check("add_fetchwait", 32'(bus.state), 0);
    tick();
    bus.mem_ready = 1'b1;
    settle();
    check("add_fetch", 32'(bus.state), 0);
    check("add_irwrite", 32'(bus.IRWrite), 1);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("add_decode", 32'(bus.state), 1);
    check("add_dec_srca", 32'(bus.ALUSrcA), 1);
    check("add_dec_srcb", 32'(bus.ALUSrcB), 1);
    tick();
    settle();
    check("add_execr", 32'(bus.state), 6);
    check("add_aluctl", 32'(bus.ALUControl), 0);
    check("add_execr_retire", 32'(bus.retire), 0);
    check("add_execr_srca", 32'(bus.ALUSrcA), 2);
    tick();
    settle();
    check("add_aluwb", 32'(bus.state), 8);
    check("add_aluwb_retire", 32'(bus.retire), 1);
    check("add_aluwb_regwrite", 32'(bus.RegWrite), 1);
    tick();
    bus.mem_ready = 1'b1;
    settle();
    check("add_back", 32'(bus.state), 0);
    check("add_back_retire", 32'(bus.retire), 0);

    // sub
    load_instr(32'h402081B3);
    tick();
    tick();
    settle();
    check("sub_execr", 32'(bus.state), 6);
    check("sub_aluctl", 32'(bus.ALUControl), 1);
    tick();
    tick();

    // slt, or, and: R-type funct3 decode
    load_instr(32'h0020A1B3);
    tick();
    tick();
    settle();
    check("slt_aluctl", 32'(bus.ALUControl), 5);
    tick();
    tick();
    load_instr(32'h0020E1B3);
    tick();
    tick();
    settle();
    check("or_aluctl", 32'(bus.ALUControl), 3);
    tick();
    tick();
    load_instr(32'h0020F1B3);
    tick();
    tick();
    settle();
    check("and_aluctl", 32'(bus.ALUControl), 2);
    tick();
    tick();

    // addi with instr[30]=1 must still add
    load_instr(32'h40008193);
    tick();
    tick();
    settle();
    check("addi_execi", 32'(bus.state), 7);
    check("addi_aluctl", 32'(bus.ALUControl), 0);
    check("addi_srcb", 32'(bus.ALUSrcB), 1);
    tick();
    tick();
    settle();
    check("addi_back", 32'(bus.state), 0);

    // lw with two wait cycles in MEMREAD
    load_instr(32'h0040A183);
    tick();
    settle();
    check("lw_decode", 32'(bus.state), 1);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("lw_memadr", 32'(bus.state), 2);
    check("lw_immsrc", 32'(bus.ImmSrc), 0);
    tick();
    settle();
    check("lw_memread0", 32'(bus.state), 3);
    check("lw_adrsrc", 32'(bus.AdrSrc), 1);
    check("lw_rw_wait", 32'(bus.RegWrite), 0);
    tick();
    settle();
    check("lw_memread1", 32'(bus.state), 3);
    tick();
    bus.mem_ready = 1'b1;
    settle();
    check("lw_memread2", 32'(bus.state), 3);
    check("lw_rw_ready", 32'(bus.RegWrite), 0);
    tick();
    settle();
    check("lw_memwb", 32'(bus.state), 4);
    check("lw_memwb_rw", 32'(bus.RegWrite), 1);
    check("lw_memwb_res", 32'(bus.ResultSrc), 1);
    check("lw_memwb_retire", 32'(bus.retire), 1);
    tick();
    settle();
    check("lw_back", 32'(bus.state), 0);
    check("lw_back_rw", 32'(bus.RegWrite), 0);

    // sw with one wait cycle in MEMWRITE
    load_instr(32'h0020A223);
    tick();
    settle();
    check("sw_immsrc", 32'(bus.ImmSrc), 1);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("sw_memadr", 32'(bus.state), 2);
    tick();
    settle();
    check("sw_memwrite0", 32'(bus.state), 5);
    check("sw_mw_wait", 32'(bus.MemWrite), 1);
    check("sw_retire_wait", 32'(bus.retire), 0);
    tick();
    bus.mem_ready = 1'b1;
    settle();
    check("sw_memwrite1", 32'(bus.state), 5);
    check("sw_mw_ready", 32'(bus.MemWrite), 1);
    check("sw_retire_ready", 32'(bus.retire), 1);
    tick();
    settle();
    check("sw_back", 32'(bus.state), 0);
    check("sw_back_mw", 32'(bus.MemWrite), 0);

    // branches
    run_branch("beq_taken", 32'h00208063, 1'b1, 1'b1);
    run_branch("beq_not", 32'h00208063, 1'b0, 1'b0);
    run_branch("bne_taken", 32'h00209063, 1'b0, 1'b1);

    // jal
    load_instr(32'h008000EF);
    tick();
    settle();
    check("jal_decode", 32'(bus.state), 1);
    check("jal_immsrc", 32'(bus.ImmSrc), 3);
    tick();
    settle();
    check("jal_state", 32'(bus.state), 10);
    check("jal_pcwrite", 32'(bus.PCWrite), 1);
    check("jal_srcb", 32'(bus.ALUSrcB), 2);
    tick();
    settle();
    check("jal_aluwb", 32'(bus.state), 8);
    tick();

    // lui
    load_instr(32'h123450B7);
    tick();
    settle();
    check("lui_immsrc", 32'(bus.ImmSrc), 4);
    tick();
    settle();
    check("lui_state", 32'(bus.state), 11);
    check("lui_srca", 32'(bus.ALUSrcA), 3);
    tick();
    settle();
    check("lui_aluwb", 32'(bus.state), 8);
    tick();

    // illegal opcode
    load_instr(32'h0000007F);
    settle();
    check("ill_fetch", 32'(bus.state), 0);
    tick();
    settle();
    check("ill_decode", 32'(bus.state), 1);
    check("ill_pulse", 32'(bus.illegal), 1);
    check("ill_retire", 32'(bus.retire), 0);
    tick();
    settle();
    check("ill_back", 32'(bus.state), 0);
    check("ill_clear", 32'(bus.illegal), 0);

    // reset held for two cycles while waiting in MEMREAD
    load_instr(32'h0040A183);
    tick();
    tick();
    bus.mem_ready = 1'b0;
    tick();
    settle();
    check("rst2_memread", 32'(bus.state), 3);
    reset = 1'b1;
    tick();
    settle();
    check("rst2_state0", 32'(bus.state), 0);
    tick();
    reset = 1'b0;
    settle();
    check("rst2_state1", 32'(bus.state), 0);
    check("rst2_memwrite", 32'(bus.MemWrite), 0);
    check("rst2_regwrite", 32'(bus.RegWrite), 0);
    check("rst2_irwrite", 32'(bus.IRWrite), 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
